jtgng_romrq_arb: RTL and testbench

//  Parametrised N-channel ROM request arbiter for the game top level: char, scroll, obj, main and sound
//  ROM clients share one SDRAM read port. Each channel keeps a one-entry cache (last address + data).

---
 rtl/jtgng_romrq_arb.sv | 152 +++++++++++++++
 tb/tb_jtgng_romrq_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_romrq_arb.sv
// N-channel ROM request arbiter: one-entry cache per channel, misses serialised onto a single
// SDRAM read port with round-robin or fixed-priority grant.
module jtgng_romrq_arb #(
  parameter int unsigned CH   = 5,
  parameter int unsigned AW   = 22,
  parameter int unsigned DW   = 16,
  parameter int unsigned PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [CH-1:0]    req_cs,
  input  logic [CH*AW-1:0] req_addr,
  output logic [CH-1:0]    req_ok,
  output logic [CH*DW-1:0] req_data,
  output logic             sdram_req,
  output logic [AW-1:0]    sdram_addr,
  input  logic             sdram_ack,
  input  logic             sdram_rdy,
  input  logic [DW-1:0]    sdram_din,
  output logic             busy
);

  localparam int unsigned PW = $clog2(CH);

  typedef enum logic [1:0] {StIdle, StWaitAck, StWaitData} state_e;

  state_e          r_state, w_state_d;
  logic [CH-1:0]   r_valid, w_valid_d;
  logic [AW-1:0]   r_last_addr [CH];
  logic [DW-1:0]   r_data [CH];
  logic [PW-1:0]   r_rr, w_rr_d;
  logic [PW-1:0]   r_gsel, w_gsel_d;
  logic            r_sdram_req, w_sdram_req_d;
  logic [AW-1:0]   r_sdram_addr, w_sdram_addr_d;
  logic            r_flush_pend, w_flush_pend_d;

  logic [AW-1:0]   w_addr [CH];
  logic [CH-1:0]   w_pend;
  logic [PW-1:0]   w_grant;
  logic [PW:0]     w_idx;
  logic            w_found;
  logic            w_fill;

  always_comb begin
    req_ok   = '0;
    req_data = '0;
    for (int i = 0; i < int'(CH); i++) begin
      w_addr[i] = req_addr[i*AW +: AW];
      req_ok[i] = req_cs[i] & r_valid[i] & (w_addr[i] == r_last_addr[i]);
      req_data[i*DW +: DW] = r_data[i];
    end
  end

  assign w_pend = req_cs & ~req_ok;

  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    if (PRIO != 0) begin
      for (int i = int'(CH) - 1; i >= 0; i--) begin
        if (w_pend[i]) w_grant = PW'(i);
      end
    end else begin
      // Scan from the rr pointer, wrapping explicitly at CH-1.
      for (int k = 0; k < int'(CH); k++) begin
        w_idx = {1'b0, r_rr} + (PW+1)'(k);
        if (w_idx >= (PW+1)'(CH)) w_idx = w_idx - (PW+1)'(CH);
        if (!w_found && w_pend[w_idx[PW-1:0]]) begin
          w_grant = w_idx[PW-1:0];
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_valid_d      = r_valid;
    w_rr_d         = r_rr;
    w_gsel_d       = r_gsel;
    w_sdram_req_d  = r_sdram_req;
    w_sdram_addr_d = r_sdram_addr;
    w_flush_pend_d = r_flush_pend;
    w_fill         = 1'b0;
    if (flush) w_valid_d = '0;
    unique case (r_state)
      StIdle: begin
        if (|w_pend) begin
          w_state_d      = StWaitAck;
          w_gsel_d       = w_grant;
          w_sdram_addr_d = w_addr[w_grant];
          w_sdram_req_d  = 1'b1;
          if (PRIO == 0) w_rr_d = (w_grant == PW'(CH - 1)) ? '0 : w_grant + 1'b1;
        end
      end
      StWaitAck: begin
        if (flush) w_flush_pend_d = 1'b1;
        if (sdram_ack) begin
          w_sdram_req_d = 1'b0;
          if (sdram_rdy) w_fill = 1'b1;
          else w_state_d = StWaitData;
        end
      end
      StWaitData: begin
        if (flush) w_flush_pend_d = 1'b1;
        if (sdram_rdy) w_fill = 1'b1;
      end
      default: w_state_d = StIdle;
    endcase
    // Data fetched across a flush is kept but never marked valid.
    if (w_fill) begin
      w_state_d         = StIdle;
      w_flush_pend_d    = 1'b0;
      w_valid_d[r_gsel] = ~(flush | r_flush_pend);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_valid      <= '0;
      r_rr         <= '0;
      r_gsel       <= '0;
      r_sdram_req  <= 1'b0;
      r_sdram_addr <= '0;
      r_flush_pend <= 1'b0;
      for (int i = 0; i < int'(CH); i++) begin
        r_last_addr[i] <= '0;
        r_data[i]      <= '0;
      end
    end else begin
      r_state      <= w_state_d;
      r_valid      <= w_valid_d;
      r_rr         <= w_rr_d;
      r_gsel       <= w_gsel_d;
      r_sdram_req  <= w_sdram_req_d;
      r_sdram_addr <= w_sdram_addr_d;
      r_flush_pend <= w_flush_pend_d;
      if (w_fill) begin
        r_data[r_gsel]      <= sdram_din;
        r_last_addr[r_gsel] <= r_sdram_addr;
      end
    end
  end

  assign sdram_req  = r_sdram_req;
  assign sdram_addr = r_sdram_addr;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_jtgng_romrq_arb.sv
// Bench for jtgng_romrq_arb: a round-robin and a fixed-priority instance share client inputs;
// both are tracked every cycle by a transaction-level cache model.
module tb_jtgng_romrq_arb;
  localparam int CH = 5;
  localparam int AW = 22;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [CH-1:0]    cs = '0;
  logic [CH*AW-1:0] addr = '0;
  logic [1:0]       ack = '0, rdy = '0;
  logic [DW-1:0]    din [2];
  logic [CH-1:0]    ok [2];
  logic [CH*DW-1:0] dat [2];
  logic [1:0]       sreq, busy;
  logic [AW-1:0]    saddr [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jtgng_romrq_arb #(.CH(CH), .AW(AW), .DW(DW), .PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_cs(cs), .req_addr(addr),
    .req_ok(ok[0]), .req_data(dat[0]), .sdram_req(sreq[0]), .sdram_addr(saddr[0]),
    .sdram_ack(ack[0]), .sdram_rdy(rdy[0]), .sdram_din(din[0]), .busy(busy[0])
  );

  jtgng_romrq_arb #(.CH(CH), .AW(AW), .DW(DW), .PRIO(1)) u_fx (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_cs(cs), .req_addr(addr),
    .req_ok(ok[1]), .req_data(dat[1]), .sdram_req(sreq[1]), .sdram_addr(saddr[1]),
    .sdram_ack(ack[1]), .sdram_rdy(rdy[1]), .sdram_din(din[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-channel cache contents plus at most one outstanding fetch per instance.
  logic [CH-1:0] mv [2];
  logic [AW-1:0] ma [2][CH];
  logic [DW-1:0] md [2][CH];
  int            mrr [2];
  bit            tact [2], tacked [2], tfl [2];
  int            tch [2];
  logic [AW-1:0] taddr [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = '0; mrr[m] = 0; tact[m] = 0; tacked[m] = 0; tfl[m] = 0; tch[m] = 0;
      taddr[m] = '0;
      for (int i = 0; i < CH; i++) begin
        ma[m][i] = '0; md[m][i] = '0;
      end
    end
  endtask

  function automatic logic [CH-1:0] exp_ok(input int m);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = cs[i] & mv[m][i] & (addr[i*AW +: AW] == ma[m][i]);
    return r;
  endfunction

  // Grant = pending channel with the smallest distance from the priority origin.
  function automatic int pick(input int m, input logic [CH-1:0] pend);
    int best = -1;
    int bc = CH + 1;
    for (int i = 0; i < CH; i++) begin
      int c;
      c = (m == 1) ? i : (i - mrr[m] + CH) % CH;
      if (pend[i] && c < bc) begin
        bc = c; best = i;
      end
    end
    return best;
  endfunction

  task automatic model_check();
    logic [CH*DW-1:0] ed;
    if (!rst_n) model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < CH; i++) ed[i*DW +: DW] = md[m][i];
      chk($sformatf("mdl%0d_ok", m), ok[m], exp_ok(m));
      chk($sformatf("mdl%0d_data", m), dat[m], ed);
      chk($sformatf("mdl%0d_req", m), sreq[m], tact[m] & ~tacked[m]);
      chk($sformatf("mdl%0d_addr", m), saddr[m], taddr[m]);
      chk($sformatf("mdl%0d_busy", m), busy[m], tact[m]);
    end
  endtask

  task automatic model_advance();
    logic [CH-1:0] pend;
    bit done;
    int g;
    if (!rst_n) return;
    for (int m = 0; m < 2; m++) begin
      pend = cs & ~exp_ok(m);
      done = 0;
      if (flush) mv[m] = '0;
      if (!tact[m]) begin
        if (pend != 0) begin
          g = pick(m, pend);
          tact[m] = 1; tacked[m] = 0; tch[m] = g; taddr[m] = addr[g*AW +: AW];
          if (m == 0) mrr[m] = (g + 1) % CH;
        end
      end else begin
        if (!tacked[m]) begin
          if (ack[m]) begin
            if (rdy[m]) done = 1;
            else tacked[m] = 1;
          end
        end else if (rdy[m]) done = 1;
        if (done) begin
          md[m][tch[m]] = din[m];
          ma[m][tch[m]] = taddr[m];
          mv[m][tch[m]] = !(tfl[m] || flush);
          tact[m] = 0; tfl[m] = 0;
        end else if (flush) tfl[m] = 1;
      end
    end
  endtask

  // Called at a falling edge; returns 1 time unit after the next rising edge.
  task automatic adv();
    model_check();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    adv();
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; addr = '0;
    for (int k = 0; k < 4; k++) begin
      cs = '1; ack = k[0] ? 2'b11 : 2'b00; rdy = k[1] ? 2'b11 : 2'b00;
      @(negedge clk);
      chk("rst_req", sreq, 2'b00);
      chk("rst_busy", busy, 2'b00);
      chk("rst_ok", {ok[1], ok[0]}, '0);
      adv();
    end
    cs = '0; ack = '0; rdy = '0;
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input int m, output logic [AW-1:0] a);
    int n = 0;
    @(negedge clk);
    while (!sreq[m] && n < 20) begin
      adv();
      @(negedge clk);
      n++;
    end
    chk($sformatf("req_seen%0d", m), sreq[m], 1'b1);
    a = saddr[m];
    adv();
  endtask

  task automatic xact(input int m, input logic [DW-1:0] d, output logic [AW-1:0] a);
    wait_req(m, a);
    ack = 2'b11;
    step();
    ack = 2'b00; rdy = 2'b11; din[0] = d; din[1] = d;
    step();
    rdy = 2'b00;
  endtask

  typedef struct {
    logic [CH-1:0] cs;
    logic [AW-1:0] a0, a1;
    logic          ack, rdy;
    logic [DW-1:0] din;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic [CH-1:0] e_ok;
    logic          e_busy;
    logic [DW-1:0] e_d0, e_d1;
  } vec_t;

  function automatic vec_t row(input logic [CH-1:0] c, input logic [AW-1:0] a0, a1,
                               input logic k, r, input logic [DW-1:0] d, input logic eq,
                               input logic [AW-1:0] ea, input logic [CH-1:0] eo,
                               input logic eb, input logic [DW-1:0] d0, d1);
    vec_t v;
    v.cs = c; v.a0 = a0; v.a1 = a1; v.ack = k; v.rdy = r; v.din = d; v.e_req = eq;
    v.e_addr = ea; v.e_ok = eo; v.e_busy = eb; v.e_d0 = d0; v.e_d1 = d1;
    return v;
  endfunction

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    vec_t tbl [18];
    logic [AW-1:0] a;
    din[0] = '0; din[1] = '0;
    // Miss then hit on ch0, address change mid-flight on ch1, ack+rdy together, stray ack/rdy.
    tbl[0]  = row(5'h01, 'h100, 'h10, 0, 0, 'h0,    0, 'h000, 5'h00, 0, 'h0,    'h0);
    tbl[1]  = row(5'h01, 'h100, 'h10, 0, 0, 'h0,    1, 'h100, 5'h00, 1, 'h0,    'h0);
    tbl[2]  = row(5'h01, 'h100, 'h10, 1, 0, 'h0,    1, 'h100, 5'h00, 1, 'h0,    'h0);
    tbl[3]  = row(5'h01, 'h100, 'h10, 0, 0, 'h0,    0, 'h100, 5'h00, 1, 'h0,    'h0);
    tbl[4]  = row(5'h01, 'h100, 'h10, 0, 1, 'hBEEF, 0, 'h100, 5'h00, 1, 'h0,    'h0);
    tbl[5]  = row(5'h01, 'h100, 'h10, 0, 0, 'h0,    0, 'h100, 5'h01, 0, 'hBEEF, 'h0);
    tbl[6]  = row(5'h01, 'h100, 'h10, 0, 0, 'h0,    0, 'h100, 5'h01, 0, 'hBEEF, 'h0);
    tbl[7]  = row(5'h01, 'h100, 'h10, 0, 0, 'h0,    0, 'h100, 5'h01, 0, 'hBEEF, 'h0);
    tbl[8]  = row(5'h03, 'h100, 'h10, 0, 0, 'h0,    0, 'h100, 5'h01, 0, 'hBEEF, 'h0);
    tbl[9]  = row(5'h03, 'h100, 'h11, 0, 0, 'h0,    1, 'h010, 5'h01, 1, 'hBEEF, 'h0);
    tbl[10] = row(5'h03, 'h100, 'h11, 1, 0, 'h0,    1, 'h010, 5'h01, 1, 'hBEEF, 'h0);
    tbl[11] = row(5'h03, 'h100, 'h11, 0, 1, 'h1234, 0, 'h010, 5'h01, 1, 'hBEEF, 'h0);
    tbl[12] = row(5'h03, 'h100, 'h11, 0, 0, 'h0,    0, 'h010, 5'h01, 0, 'hBEEF, 'h1234);
    tbl[13] = row(5'h03, 'h100, 'h11, 0, 0, 'h0,    1, 'h011, 5'h01, 1, 'hBEEF, 'h1234);
    tbl[14] = row(5'h03, 'h100, 'h11, 1, 1, 'h5555, 1, 'h011, 5'h01, 1, 'hBEEF, 'h1234);
    tbl[15] = row(5'h03, 'h100, 'h11, 0, 0, 'h0,    0, 'h011, 5'h03, 0, 'hBEEF, 'h5555);
    tbl[16] = row(5'h03, 'h100, 'h11, 1, 1, 'h7777, 0, 'h011, 5'h03, 0, 'hBEEF, 'h5555);
    tbl[17] = row(5'h03, 'h100, 'h11, 0, 0, 'h0,    0, 'h011, 5'h03, 0, 'hBEEF, 'h5555);

    @(posedge clk);
    #1;
    do_reset();

    for (int r = 0; r < 18; r++) begin
      cs = tbl[r].cs; set_addr(0, tbl[r].a0); set_addr(1, tbl[r].a1);
      ack = {2{tbl[r].ack}}; rdy = {2{tbl[r].rdy}}; din[0] = tbl[r].din; din[1] = tbl[r].din;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("vec%0d_req%0d", r, m), sreq[m], tbl[r].e_req);
        chk($sformatf("vec%0d_addr%0d", r, m), saddr[m], tbl[r].e_addr);
        chk($sformatf("vec%0d_ok%0d", r, m), ok[m], tbl[r].e_ok);
        chk($sformatf("vec%0d_busy%0d", r, m), busy[m], tbl[r].e_busy);
        chk($sformatf("vec%0d_data%0d", r, m), dat[m][2*DW-1:0], {tbl[r].e_d1, tbl[r].e_d0});
      end
      adv();
    end
    ack = '0; rdy = '0;

    // Round-robin: all miss together, then ch1/ch3 with rr back at 0.
    do_reset();
    cs = '1;
    for (int i = 0; i < CH; i++) set_addr(i, AW'('h200 + i));
    for (int k = 0; k < CH; k++) begin
      xact(0, DW'('h1000 + k), a);
      chk($sformatf("rr_all_%0d", k), a, AW'('h200 + k));
    end
    @(negedge clk);
    chk("rr_all_hit", ok[0], 5'h1f);
    adv();
    set_addr(1, 'h300); set_addr(3, 'h301);
    xact(0, 'h2000, a);
    chk("rr_13_first", a, 'h300);
    set_addr(1, 'h302);
    xact(0, 'h2001, a);
    chk("rr_13_second", a, 'h301);
    xact(0, 'h2002, a);
    chk("rr_13_third", a, 'h302);

    // Fixed priority: ch0 keeps re-missing, ch4 starves until ch0 lets go.
    do_reset();
    cs = 5'b10001; set_addr(4, 'h400); set_addr(0, 'h500);
    for (int k = 0; k < 4; k++) begin
      xact(1, DW'('h3000 + k), a);
      chk($sformatf("fix_ch0_%0d", k), a, AW'('h500 + k));
      set_addr(0, AW'('h501 + k));
    end
    cs = 5'b10000;
    @(negedge clk);
    chk("fix_ch4_starved", ok[1][4], 1'b0);
    adv();
    xact(1, 'h4444, a);
    chk("fix_ch4_late", a, 'h400);
    @(negedge clk);
    chk("fix_ch4_hit", ok[1][4], 1'b1);
    adv();

    // Flush while waiting for data, then flush while idle.
    do_reset();
    cs = 5'b00100; set_addr(2, 'h3FF);
    wait_req(0, a);
    chk("fl_addr", a, 'h3FF);
    ack = 2'b11; step(); ack = 2'b00;
    flush = 1'b1; step(); flush = 1'b0;
    rdy = 2'b11; din[0] = 'hAAAA; din[1] = 'hAAAA; step(); rdy = 2'b00;
    @(negedge clk);
    chk("fl_ok_cleared", ok[0][2], 1'b0);
    chk("fl_data_kept", dat[0][2*DW +: DW], 'hAAAA);
    adv();
    xact(0, 'hBBBB, a);
    chk("fl_rerequest", a, 'h3FF);
    @(negedge clk);
    chk("fl_refill_hit", ok[0][2], 1'b1);
    adv();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_idle_before", ok[0][2], 1'b1);
    adv();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_idle_after", ok[0][2], 1'b0);
    adv();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      int j;
      if ($urandom_range(7) == 0) begin
        j = $urandom_range(CH - 1);
        cs[j] = ~cs[j];
      end
      if ($urandom_range(5) == 0) begin
        j = $urandom_range(CH - 1);
        set_addr(j, AW'(j * 16 + $urandom_range(3)));
      end
      flush = ($urandom_range(63) == 0);
      for (int m = 0; m < 2; m++) begin
        ack[m] = ($urandom_range(2) == 0);
        rdy[m] = ($urandom_range(2) == 0);
        din[m] = DW'($urandom);
      end
      if ($urandom_range(999) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
